// File: rtl/pe_frac_pkg.sv
// Shared Q4.12 constants, FSM state type and the ln-threshold table for the 12b_frac PE.
// LOG_THR[idx] = round(e^(idx-8) * 4096); idx 11..15 are unreachable sentinels.
package pe_frac_pkg;

  localparam int          FRAC_BITS   = 12;
  localparam logic [15:0] ONE         = 16'h1000;
  localparam int          EXP_MIN     = -8;
  localparam int          EXP_MAX_REP = 2;
  localparam int          THR_W       = 17;
  localparam int          IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } log_state_e;

  localparam logic [THR_W-1:0] LOG_THR [16] = '{
    17'd1,     17'd4,     17'd10,    17'd28,
    17'd75,    17'd204,   17'd554,   17'd1507,
    17'd4096,  17'd11134, 17'd30266, 17'h1FFFF,
    17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF
  };

endpackage

// File: rtl/lut_log_scale_rom.sv
// Combinational index-to-threshold lookup into LOG_THR.
module log_thr_rom
  import pe_frac_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [THR_W-1:0] thr
);

  // table read
  always_comb begin
    thr = LOG_THR[idx];
  end

endmodule

// File: rtl/lut_log_scale.sv
// k = floor(ln x) for Q4.12 x via a 4-step binary search over LOG_THR, valid/ready on both sides.
// Optional residual output (x - thr[k]) is built only when LOG_RESIDUAL_EN is defined.
module lut_log_scale
  import pe_frac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int EXP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_int,
  output logic              zero_flag,
  output logic              sat_flag
`ifdef LOG_RESIDUAL_EN
  ,
  output logic [DATA_W-1:0] residual
`endif
);

  log_state_e        state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        step_q, step_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [EXP_W-1:0]  exp_int_q, exp_int_d;
  logic              zero_flag_q, zero_flag_d;
  logic              sat_flag_q, sat_flag_d;

  logic [IDX_W-1:0]  cand_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [THR_W-1:0]  thr_cand_s;

  assign cand_s = idx_q | (4'd1 << step_q);

  log_thr_rom u_rom_cmp (
    .idx (cand_s),
    .thr (thr_cand_s)
  );

  // The candidate is kept when its threshold does not exceed x (x zero-extended to 17 bits).
  assign idx_next_s = (thr_cand_s <= {1'b0, x_q}) ? cand_s : idx_q;

`ifdef LOG_RESIDUAL_EN
  logic [DATA_W-1:0] residual_q, residual_d;
  logic [THR_W-1:0]  thr_sel_s;

  log_thr_rom u_rom_res (
    .idx (idx_next_s),
    .thr (thr_sel_s)
  );
`endif

  // next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    idx_d       = idx_q;
    step_d      = step_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    exp_int_d   = exp_int_q;
    zero_flag_d = zero_flag_q;
    sat_flag_d  = sat_flag_q;
`ifdef LOG_RESIDUAL_EN
    residual_d  = residual_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d        = in_data;
          idx_d      = 4'd0;
          step_d     = 2'd3;
          in_ready_d = 1'b0;
          state_d    = ST_SEARCH;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        idx_d  = idx_next_s;
        step_d = step_q - 2'd1;
        if (step_q == 2'd0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          exp_int_d   = EXP_W'(int'(idx_next_s) + EXP_MIN);
          zero_flag_d = (x_q == '0);
          sat_flag_d  = (idx_next_s == IDX_W'(EXP_MAX_REP - EXP_MIN));
`ifdef LOG_RESIDUAL_EN
          // x = 0 still lands on idx 0 (thr 1); clamp so the residual never wraps.
          if (x_q == '0) begin
            residual_d = '0;
          end else begin
            residual_d = x_q - thr_sel_s[DATA_W-1:0];
          end
`endif
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset drops any in-flight sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      idx_q       <= '0;
      step_q      <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      exp_int_q   <= '0;
      zero_flag_q <= 1'b0;
      sat_flag_q  <= 1'b0;
`ifdef LOG_RESIDUAL_EN
      residual_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      exp_int_q   <= exp_int_d;
      zero_flag_q <= zero_flag_d;
      sat_flag_q  <= sat_flag_d;
`ifdef LOG_RESIDUAL_EN
      residual_q  <= residual_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign exp_int   = exp_int_q;
  assign zero_flag = zero_flag_q;
  assign sat_flag  = sat_flag_q;
`ifdef LOG_RESIDUAL_EN
  assign residual  = residual_q;
`endif

endmodule

// File: tb/tb_lut_log_scale.sv
// Self-checking bench for lut_log_scale: directed vector table, backpressure, mid-search reset,
// and random x against an e^k threshold model. Residual checks are active with LOG_RESIDUAL_EN.
module tb_lut_log_scale;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  exp_int;
  logic        zero_flag;
  logic        sat_flag;
`ifdef LOG_RESIDUAL_EN
  logic [15:0] residual;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lut_log_scale #(.DATA_W(16), .EXP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_int   (exp_int),
    .zero_flag (zero_flag),
    .sat_flag  (sat_flag)
`ifdef LOG_RESIDUAL_EN
    ,
    .residual  (residual)
`endif
  );

  typedef struct {
    logic [15:0] x;
    logic [3:0]  exp;
    bit          zero;
    bit          sat;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: thresholds are round(e^k * 4096); k is the largest k in [-8,2] with thr(k) <= x.
  function automatic int thr_of(input int k);
    real v;
    v = $exp(real'(k)) * 4096.0;
    return $rtoi(v + 0.5);
  endfunction

  function automatic int model_k(input int x);
    int k;
    k = -8;
    for (int j = -7; j <= 2; j++) begin
      if (x >= thr_of(j)) k = j;
    end
    return k;
  endfunction

  function automatic int model_res(input int x);
    if (x == 0) return 0;
    return x - thr_of(model_k(x));
  endfunction

  // Present x, count edges from the accept edge until out_valid; leaves the result waiting in DONE.
  task automatic issue(input logic [15:0] x, output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", in_ready, 1);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < 20) begin
      lat++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] x, input logic [3:0] e,
                              input bit z, input bit s, input logic [15:0] r, input int lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_exp_int"}, exp_int, e);
    chk({tag, "_zero"}, zero_flag, z);
    chk({tag, "_sat"}, sat_flag, s);
`ifdef LOG_RESIDUAL_EN
    chk({tag, "_residual"}, residual, r);
`else
    if (r != 16'd0 && x == 16'd0) chk({tag, "_zero_res_model"}, r, 0);
`endif
  endtask

  initial begin
    int lat;
    logic [3:0] e_hold;
    logic [15:0] x;
    int k;

    vecs[0]  = '{16'h1000, 4'h0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{16'd4095, 4'hF, 1'b0, 1'b0, 16'd2588};
    vecs[2]  = '{16'd11134, 4'h1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{16'd65535, 4'h2, 1'b0, 1'b1, 16'd35269};
    vecs[4]  = '{16'd0, 4'h8, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{16'd1, 4'h8, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{16'd600, 4'hE, 1'b0, 1'b0, 16'd46};
    vecs[7]  = '{16'd30266, 4'h2, 1'b0, 1'b1, 16'd0};
    vecs[8]  = '{16'd11133, 4'h0, 1'b0, 1'b0, 16'd7037};
    vecs[9]  = '{16'd1506, 4'hE, 1'b0, 1'b0, 16'd952};
    vecs[10] = '{16'd3, 4'h8, 1'b0, 1'b0, 16'd2};
    vecs[11] = '{16'd4, 4'h9, 1'b0, 1'b0, 16'd0};

    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_exp_int", exp_int, 0);
    chk("reset_zero", zero_flag, 0);
    chk("reset_sat", sat_flag, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].x, lat);
      check_result($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp, vecs[i].zero,
                   vecs[i].sat, vecs[i].res, lat);
      consume();
    end

    // Backpressure: result held for 10 cycles while a second sample waits on in_valid.
    issue(16'd600, lat);
    check_result("bp", 16'd600, 4'hE, 1'b0, 1'b0, 16'd46, lat);
    e_hold = exp_int;
    @(negedge clk);
    in_data  = 16'd65535;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_exp", exp_int, e_hold);
      chk("bp_hold_in_ready", in_ready, 0);
`ifdef LOG_RESIDUAL_EN
      chk("bp_hold_residual", residual, 46);
`endif
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", in_ready, 0);
    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < 20) begin
      lat++;
      @(posedge clk);
      #1;
    end
    check_result("bp_second", 16'd65535, 4'h2, 1'b0, 1'b1, 16'd35269, lat);
    consume();

    // Reset during the step-2 compare; no stale result may appear afterwards.
    @(negedge clk);
    in_data  = 16'd65535;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_exp_int", exp_int, 0);
    chk("midrst_sat", sat_flag, 0);
    chk("midrst_zero", zero_flag, 0);
`ifdef LOG_RESIDUAL_EN
    chk("midrst_residual", residual, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", out_valid, 0);
    end
    issue(16'd30266, lat);
    check_result("midrst_after", 16'd30266, 4'h2, 1'b0, 1'b1, 16'd0, lat);
    consume();

    // Random x, half of them clustered around the thresholds.
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) begin
        x = 16'($urandom_range(0, 65535));
      end else begin
        k = int'($urandom_range(0, 10)) - 8;
        x = 16'(thr_of(k) + int'($urandom_range(0, 2)) - 1);
      end
      issue(x, lat);
      check_result($sformatf("rnd_x%0d", x), x, 4'(model_k(int'(x))), (x == 16'd0),
                   (model_k(int'(x)) == 2), 16'(model_res(int'(x))), lat);
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
